// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a host-side FIFO; data width, parity and stop bits are parameters.
// Queued characters leave back-to-back, and each bit lasts MAIN_CLK/BAUD clock cycles.
module uart_tx_fifo #(
  parameter int MAIN_CLK   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  input  logic [DATA_BITS-1:0]             tx_data,
  output logic                             uart_tx,
  output logic                             tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int BAUD_DIVIDE = MAIN_CLK / BAUD;
  localparam int BW = $clog2(BAUD_DIVIDE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIVIDE - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity bit that makes data+parity odd (PARITY=1) or even (PARITY=2).
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY == 1);
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [LW-1:0]        level_r;
  logic [LW-1:0]        level_next_s;
  logic [2:0]           state_r;
  logic [BW-1:0]        baud_cntr_r;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] head_s;
  logic                 parity_r;
  logic                 uart_tx_r;
  logic                 tx_ready_r;
  logic                 tx_busy_r;
  logic                 push_s;
  logic                 pop_s;
  logic                 bit_end_s;
  logic                 stop_done_s;
  logic                 fifo_empty_s;
  logic                 idle_next_s;

  assign head_s = mem_r[rd_ptr_r];

  // Handshake, bit-end detection, pop decision and next FIFO level.
  always_comb begin
    push_s       = tx_valid && tx_ready_r;
    fifo_empty_s = (level_r == {LW{1'b0}});
    bit_end_s    = (state_r != ST_IDLE) && (baud_cntr_r == {BW{1'b0}});
    stop_done_s  = bit_end_s && (state_r == ST_STOP) && (bit_cnt_r == STOP_LAST);
    if ((state_r == ST_IDLE) || stop_done_s) begin
      pop_s       = !fifo_empty_s;
      idle_next_s = fifo_empty_s;
    end else begin
      pop_s       = 1'b0;
      idle_next_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // FIFO storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // Pointers, level and the registered host-side status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      tx_ready_r <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      level_r    <= level_next_s;
      tx_ready_r <= (level_next_s != LEVEL_FULL);
      tx_busy_r  <= !(idle_next_s && (level_next_s == {LW{1'b0}}));
    end
  end

  // Frame sequencer: the baud counter only runs inside a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      uart_tx_r   <= 1'b1;
      baud_cntr_r <= {BW{1'b0}};
      bit_cnt_r   <= 4'd0;
      shift_r     <= {DATA_BITS{1'b0}};
      parity_r    <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (pop_s) begin
        state_r     <= ST_START;
        uart_tx_r   <= 1'b0;
        baud_cntr_r <= BAUD_LAST;
        bit_cnt_r   <= 4'd0;
        shift_r     <= head_s;
        parity_r    <= calc_parity(head_s);
      end else begin
        uart_tx_r <= 1'b1;
      end
    end else if (!bit_end_s) begin
      baud_cntr_r <= baud_cntr_r - BW'(1);
    end else begin
      baud_cntr_r <= BAUD_LAST;
      case (state_r)
        ST_START: begin
          state_r   <= ST_DATA;
          uart_tx_r <= shift_r[0];
          bit_cnt_r <= 4'd0;
        end
        ST_DATA: begin
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_r <= 4'd0;
            if (PARITY != 0) begin
              state_r   <= ST_PARITY;
              uart_tx_r <= parity_r;
            end else begin
              state_r   <= ST_STOP;
              uart_tx_r <= 1'b1;
            end
          end else begin
            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
            uart_tx_r <= shift_r[1];
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        ST_PARITY: begin
          state_r   <= ST_STOP;
          uart_tx_r <= 1'b1;
          bit_cnt_r <= 4'd0;
        end
        ST_STOP: begin
          if (bit_cnt_r != STOP_LAST) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end else if (pop_s) begin
            // Next character starts on this very edge: no idle gap.
            state_r   <= ST_START;
            uart_tx_r <= 1'b0;
            bit_cnt_r <= 4'd0;
            shift_r   <= head_s;
            parity_r  <= calc_parity(head_s);
          end else begin
            state_r   <= ST_IDLE;
            uart_tx_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          uart_tx_r <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx    = uart_tx_r;
  assign tx_ready   = tx_ready_r;
  assign tx_busy    = tx_busy_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 7E2 and 8O1 instances at 10 clocks per bit.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, a_ready, a_tx, a_busy;
  logic [7:0] a_data;
  logic [2:0] a_level;
  logic       b_valid, b_ready, b_tx, b_busy;
  logic [6:0] b_data;
  logic [2:0] b_level;
  logic       c_valid, c_ready, c_tx, c_busy;
  logic [7:0] c_data;
  logic [2:0] c_level;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.MAIN_CLK(1000), .BAUD(100), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .tx_valid(a_valid), .tx_ready(a_ready), .tx_data(a_data),
    .uart_tx(a_tx), .tx_busy(a_busy), .fifo_level(a_level));

  uart_tx_fifo #(.MAIN_CLK(1000), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .tx_valid(b_valid), .tx_ready(b_ready), .tx_data(b_data),
    .uart_tx(b_tx), .tx_busy(b_busy), .fifo_level(b_level));

  uart_tx_fifo #(.MAIN_CLK(1000), .BAUD(100), .PARITY(1)) dut_c (
    .clk(clk), .reset(reset), .tx_valid(c_valid), .tx_ready(c_ready), .tx_data(c_data),
    .uart_tx(c_tx), .tx_busy(c_busy), .fifo_level(c_level));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_line(input int d);
    case (d)
      0:       return a_tx;
      1:       return b_tx;
      default: return c_tx;
    endcase
  endfunction

  task automatic push(input int d, input logic [7:0] data);
    case (d)
      0:       begin a_valid = 1'b1; a_data = data; end
      1:       begin b_valid = 1'b1; b_data = data[6:0]; end
      default: begin c_valid = 1'b1; c_data = data; end
    endcase
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    c_valid = 1'b0;
  endtask

  // bits[k] is the k-th bit on the line; each must hold for exactly 10 cycles.
  task automatic frame_check(input int d, input string tag, input logic [15:0] bits, input int nbits);
    int hits;
    for (int b = 0; b < nbits; b++) begin
      hits = 0;
      for (int c = 0; c < 10; c++) begin
        if (sel_line(d) === bits[b]) hits++;
        tick();
      end
      check($sformatf("%s bit%0d", tag, b), hits, 10);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] ch, input int b);
    if (b == 0) return 1'b0;
    else if (b <= 8) return ch[b-1];
    else return 1'b1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       pushed;
    int         idx;
    int         t;
    int         hi;
    int         busy_seen;
    int         mism [6];
    logic [7:0] ch;

    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = 8'h00; b_data = 7'h00; c_data = 8'h00;
    #1;
    check("rst uart_tx", a_tx, 1);
    check("rst tx_ready", a_ready, 1);
    check("rst tx_busy", a_busy, 0);
    check("rst fifo_level", a_level, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    tick();
    check("idle line", a_tx, 1);

    // 8N1, 0x55
    push(0, 8'h55);
    check("8n1 level after push", a_level, 1);
    check("8n1 busy after push", a_busy, 1);
    check("8n1 line before pop", a_tx, 1);
    tick();
    check("8n1 start fall", a_tx, 0);
    check("8n1 level after pop", a_level, 0);
    frame_check(0, "8n1", 16'h02AA, 10);
    check("8n1 busy end", a_busy, 0);
    check("8n1 line end", a_tx, 1);

    // 7E2, 0x41: 0 1000001 0 11
    push(1, 8'h41);
    tick();
    frame_check(1, "7e2", 16'h0682, 11);
    check("7e2 busy end", b_busy, 0);

    // 8O1, 0x00: parity bit 1
    push(2, 8'h00);
    tick();
    frame_check(2, "8o1", 16'h0600, 11);
    check("8o1 busy end", c_busy, 0);

    // Burst of six with tx_valid held
    idx = 0;
    for (int k = 0; k < 6; k++) mism[k] = 0;
    a_valid = 1'b1;
    a_data  = 8'h30;
    for (int e = 1; e <= 602; e++) begin
      pushed = a_valid && a_ready;
      tick();
      if (pushed) begin
        idx++;
        if (idx >= 6) a_valid = 1'b0;
        else a_data = 8'h30 + 8'(idx);
      end
      if (e >= 2 && e <= 601) begin
        t = e - 2;
        if (a_tx !== frame_bit(8'h30 + 8'(t / 100), (t % 100) / 10)) mism[t / 100]++;
      end
      if (e == 4) begin
        check("burst ready e4", a_ready, 1);
        check("burst level e4", a_level, 3);
      end
      if (e == 5) begin
        check("burst ready full", a_ready, 0);
        check("burst level full", a_level, 4);
      end
      if (e == 102) begin
        check("burst ready after pop", a_ready, 1);
        check("burst level after pop", a_level, 3);
      end
      if (e == 103) check("burst refill level", a_level, 4);
      if (e == 300) check("burst busy mid", a_busy, 1);
    end
    check("burst accepted", idx, 6);
    for (int k = 0; k < 6; k++) check($sformatf("burst frame%0d", k), mism[k], 0);
    check("burst busy end", a_busy, 0);
    check("burst line end", a_tx, 1);

    // Push on the edge a stop bit ends with one character queued
    for (int k = 0; k < 3; k++) mism[k] = 0;
    for (int e = 1; e <= 302; e++) begin
      case (e)
        1:       begin a_valid = 1'b1; a_data = 8'hA5; end
        3:       begin a_valid = 1'b1; a_data = 8'h3C; end
        102:     begin a_valid = 1'b1; a_data = 8'h81; end
        default: a_valid = 1'b0;
      endcase
      tick();
      if (e >= 2 && e <= 301) begin
        t  = e - 2;
        ch = (t < 100) ? 8'hA5 : ((t < 200) ? 8'h3C : 8'h81);
        if (a_tx !== frame_bit(ch, (t % 100) / 10)) mism[t / 100]++;
      end
      if (e == 101) check("pushpop level before", a_level, 1);
      if (e == 102) check("pushpop level same", a_level, 1);
    end
    a_valid = 1'b0;
    for (int k = 0; k < 3; k++) check($sformatf("pushpop frame%0d", k), mism[k], 0);
    check("pushpop level end", a_level, 0);
    check("pushpop busy end", a_busy, 0);

    // Reset in the 4th data bit of 0x0F with two characters queued
    push(0, 8'h0F);
    tick();
    push(0, 8'h11);
    push(0, 8'h22);
    repeat (42) tick();
    check("prereset level", a_level, 2);
    check("prereset busy", a_busy, 1);
    #3 reset = 1'b1;
    #1;
    check("async rst line", a_tx, 1);
    check("async rst level", a_level, 0);
    check("async rst ready", a_ready, 1);
    check("async rst busy", a_busy, 0);
    #2 reset = 1'b0;
    hi = 0;
    busy_seen = 0;
    repeat (150) begin
      tick();
      if (a_tx === 1'b1) hi++;
      if (a_busy !== 1'b0) busy_seen++;
    end
    check("post rst line high", hi, 150);
    check("post rst no busy", busy_seen, 0);
    check("post rst level", a_level, 0);
    push(0, 8'h5A);
    check("post rst push level", a_level, 1);
    tick();
    check("post rst start", a_tx, 0);
    repeat (100) tick();
    check("post rst frame done", a_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
